// File: rtl/rep3_serial_tx.sv
// Repetition-coded serial transmitter: sends start / NBITS data (LSB first) / stop,
// holding every symbol for REP cycles so the receiver can majority-vote each one.
module rep3_serial_tx #(
    parameter int NBITS = 8,
    parameter int REP   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_data,
    output logic             tx_out,
    output logic             tx_busy
);

    localparam int RW = (REP > 1) ? $clog2(REP) : 1;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      rep_cnt_q, rep_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]   data_q, data_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               rep_last;
    logic               bit_last;

    assign in_rdy   = (state_q == IDLE) && rst_n;
    assign rep_last = (rep_cnt_q == RW'(REP - 1));
    assign bit_last = (bit_cnt_q == BW'(NBITS - 1));

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;

        case (state_q)
            IDLE: begin
                if (in_val && in_rdy) begin
                    data_d    = in_data;
                    rep_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (rep_last) begin
                    rep_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
                end
            end
            DATA: begin
                if (rep_last) begin
                    rep_cnt_d = '0;
                    // Clear rather than increment on the last bit so bit_cnt never wraps.
                    if (bit_last) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
                end
            end
            STOP: begin
                if (rep_last) begin
                    rep_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Line level and busy are computed from the next state so the pin comes straight off a flop.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_cnt_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_out  = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Directed bench for rep3_serial_tx: table-driven frames, handshake spacing,
// mid-frame changes and reset, majority-vote loopback, and a REP=1 / NBITS=4 instance.
module tb_rep3_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       tx_out;
    logic       tx_busy;

    logic       in_val1;
    logic       in_rdy1;
    logic [3:0] in_data1;
    logic       tx_out1;
    logic       tx_busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc[$];
    logic [7:0] hs_dat[$];

    always #5 clk = ~clk;

    rep3_serial_tx #(.NBITS(8), .REP(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .tx_out  (tx_out),
        .tx_busy (tx_busy)
    );

    rep3_serial_tx #(.NBITS(4), .REP(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_val  (in_val1),
        .in_rdy  (in_rdy1),
        .in_data (in_data1),
        .tx_out  (tx_out1),
        .tx_busy (tx_busy1)
    );

    // Record the cycle index and word of every handshake of the main DUT.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && in_val === 1'b1 && in_rdy === 1'b1) begin
            hs_cyc.push_back(cyc);
            hs_dat.push_back(in_data);
        end
        cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] pat;   // symbol i of the frame is pat[i]: start, d0..d7, stop
        string      name;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] expand(input logic [9:0] pat);
        logic [29:0] r;
        for (int s = 0; s < 10; s++)
            for (int k = 0; k < 3; k++)
                r[s*3+k] = pat[s];
        return r;
    endfunction

    // Starts at a negedge; returns at the negedge holding frame cycle 0.
    task automatic do_hs(input logic [7:0] d, input bit keep);
        int n;
        n = 0;
        in_val  = 1'b1;
        in_data = d;
        while (in_rdy !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (in_rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: in_rdy=%b after %0d cycles, required 1", in_rdy, n);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) in_val = 1'b0;
    endtask

    task automatic capture(input logic [9:0] pat, input string name,
                           input int poke_at, input logic [7:0] poke_data);
        logic [29:0] got;
        int busy_n;
        int rdy_n;
        busy_n = 0;
        rdy_n  = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == poke_at) in_data = poke_data;
            got[i] = tx_out;
            if (tx_busy === 1'b1) busy_n++;
            if (in_rdy === 1'b1) rdy_n++;
            @(negedge clk);
        end
        chk({name, "_bits"}, {2'b00, got}, {2'b00, expand(pat)});
        chk({name, "_busy_cycles"}, busy_n, 30);
        chk({name, "_rdy_cycles"}, rdy_n, 0);
        chk({name, "_idle_busy"}, {31'd0, tx_busy}, 32'd0);
        chk({name, "_idle_rdy"}, {31'd0, in_rdy}, 32'd1);
    endtask

    task automatic loopback(input logic [7:0] w);
        logic [9:0] rx;
        logic [2:0] s;
        int flip;
        do_hs(w, 1'b0);
        for (int sym = 0; sym < 10; sym++) begin
            flip = $urandom_range(0, 2);
            for (int k = 0; k < 3; k++) begin
                s[k] = tx_out ^ (k == flip);
                @(negedge clk);
            end
            rx[sym] = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
        end
        chk("loopback", {22'd0, rx}, {22'd0, 1'b1, w, 1'b0});
    endtask

    initial begin
        int base;
        logic [5:0] got6;
        int busy6;

        vecs[0] = '{data: 8'hA5, pat: 10'h34A, name: "frame_a5"};
        vecs[1] = '{data: 8'h00, pat: 10'h200, name: "frame_00"};
        vecs[2] = '{data: 8'hFF, pat: 10'h3FE, name: "frame_ff"};
        vecs[3] = '{data: 8'h3C, pat: 10'h278, name: "frame_3c"};

        rst_n    = 1'b0;
        in_val   = 1'b0;
        in_data  = 8'h00;
        in_val1  = 1'b0;
        in_data1 = 4'h0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rdy", {31'd0, in_rdy}, 32'd0);
        chk("rst_tx1", {31'd0, tx_out1}, 32'd1);
        chk("rst_rdy1", {31'd0, in_rdy1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", {31'd0, in_rdy}, 32'd1);
        chk("post_rst_tx", {31'd0, tx_out}, 32'd1);
        chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            do_hs(vecs[v].data, 1'b0);
            capture(vecs[v].pat, vecs[v].name, -1, 8'h00);
        end

        // in_val held high across two words: back-to-back handshakes 31 cycles apart.
        base = hs_cyc.size();
        do_hs(8'h3C, 1'b1);
        in_data = 8'hC3;
        capture(10'h278, "held_3c", -1, 8'h00);
        do_hs(8'hC3, 1'b0);
        capture(10'h386, "held_c3", -1, 8'h00);
        chk("held_hs_count", hs_cyc.size() - base, 2);
        if (hs_cyc.size() >= base + 2) begin
            chk("held_spacing", hs_cyc[base+1] - hs_cyc[base], 31);
            chk("held_second_word", {24'd0, hs_dat[base+1]}, 32'hC3);
        end

        // Data changed mid-frame with in_val high is ignored until the next IDLE.
        base = hs_cyc.size();
        do_hs(8'hA5, 1'b1);
        capture(10'h34A, "midchg_a5", 12, 8'hFF);
        do_hs(8'hFF, 1'b0);
        capture(10'h3FE, "midchg_ff", -1, 8'h00);
        chk("midchg_hs_count", hs_cyc.size() - base, 2);
        if (hs_cyc.size() >= base + 2) begin
            chk("midchg_first_word", {24'd0, hs_dat[base]}, 32'hA5);
            chk("midchg_spacing", hs_cyc[base+1] - hs_cyc[base], 31);
        end

        // Reset at frame cycle 10 (bit 2 of 0x5A, a zero) abandons the frame.
        do_hs(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_rst_tx", {31'd0, tx_out}, 32'd0);
        chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx_out}, 32'd1);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
        chk("midrst_rdy", {31'd0, in_rdy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_rdy", {31'd0, in_rdy}, 32'd1);
        do_hs(8'h0F, 1'b0);
        capture(10'h21E, "after_rst_0f", -1, 8'h00);

        loopback(8'h00);
        loopback(8'hFF);
        for (int i = 0; i < 4; i++) loopback(8'($urandom_range(0, 255)));

        // REP=1, NBITS=4 instance: word 0x9 gives symbols 0,1,0,0,1,1.
        in_val1  = 1'b1;
        in_data1 = 4'h9;
        chk("rep1_rdy", {31'd0, in_rdy1}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_val1 = 1'b0;
        busy6 = 0;
        for (int i = 0; i < 6; i++) begin
            got6[i] = tx_out1;
            if (tx_busy1 === 1'b1) busy6++;
            @(negedge clk);
        end
        chk("rep1_bits", {26'd0, got6}, 32'h32);
        chk("rep1_busy_cycles", busy6, 6);
        chk("rep1_idle_busy", {31'd0, tx_busy1}, 32'd0);
        chk("rep1_idle_tx", {31'd0, tx_out1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rep3_serial_tx.md
Name: rep3_serial_tx

Overview:
- Serial transmitter for the repetition-coded link.
- Accepts a parallel word via a val/rdy handshake and drives it onto a single serial line as start / data / stop symbols.
- Each symbol is held for REP consecutive cycles, so the receiving end can recover every symbol with a pair/triple (majority) vote over its REP samples.
- Sits between a producer and the serial pin; it is the transmit end of the link whose receiver is built from majority voters.

Parameters:
- NBITS, 8, data word width in bits; legal range 1..32.
- REP, 3, cycles each symbol is held; must be odd and ≥1; 3 matches the three-input majority receiver.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_val  input  1  producer asserts that in_data is valid.
- in_rdy  output  1  block can accept a word this cycle.
- in_data  input  NBITS  word to transmit.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_n==0 at a rising edge):
  - state=IDLE; tx_out=1, tx_busy=0, counters=0, data register=0.
  - in_rdy=0 while rst_n is low. in_rdy is combinational: (state==IDLE) & rst_n.
- States: IDLE, START, DATA, STOP. All outputs except in_rdy are registered or decoded from registered state.
- IDLE:
  - tx_out=1, tx_busy=0, in_rdy=1.
  - Handshake = in_val & in_rdy at a rising edge. On handshake: capture in_data, clear rep_cnt and bit_cnt, go to START.
  - in_val without in_rdy has no effect.
- START: tx_out=0 for REP cycles (rep_cnt 0..REP-1). At rep_cnt==REP-1: clear rep_cnt, go to DATA.
- DATA:
  - tx_out = data_reg[bit_cnt], LSB first. Each bit is held for REP cycles.
  - At rep_cnt==REP-1: rep_cnt←0 and bit_cnt←bit_cnt+1.
  - At rep_cnt==REP-1 and bit_cnt==NBITS-1: go to STOP.
- STOP: tx_out=1 for REP cycles, then go to IDLE.
- tx_busy=1 in START, DATA and STOP.
- Timing:
  - Handshake at edge t → first start cycle t+1.
  - Frame length = (NBITS+2)*REP cycles; 30 cycles for the defaults.
  - IDLE lasts at least one cycle between frames, so the minimum handshake spacing is (NBITS+2)*REP+1 cycles (31 for the defaults).
- Counter widths: rep_cnt is $clog2(REP) bits, minimum 1; bit_cnt is $clog2(NBITS) bits, minimum 1. Neither counter may wrap past its terminal value.
- REP=1: every symbol lasts exactly one cycle; the rep_cnt terminal condition is always true.
- in_data and in_val changes while tx_busy=1 are ignored. The captured word is stable for the whole frame.
- Reset mid-frame: at the next edge with rst_n==0, tx_out returns to 1 and state returns to IDLE. The partial frame is abandoned and not resumed; no handshake completes during reset.
- No X on any output after the first reset edge.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release → tx_out=1, tx_busy=0, in_rdy=0 during reset and 1 afterwards.
- Single frame with in_data=0xA5 and a one-cycle in_val:
  - 3 cycles of 0, then the bit sequence 1,0,1,0,0,1,0,1, each bit held 3 cycles, then 3 cycles of 1.
  - tx_busy high for exactly 30 cycles; in_rdy low for the same 30 cycles.
- in_val held high with words 0x3C then 0xC3 → second handshake exactly 31 cycles after the first; the second frame's bits match 0xC3.
- Change in_data to 0xFF mid-frame while in_val=1 → the frame in flight is unchanged; 0xFF is accepted only at the next IDLE.
- Assert rst_n=0 at cycle 10 of a frame → tx_out=1 and tx_busy=0 on the following cycle; a new frame for 0x0F afterwards is correct.
- Loopback:
  - Feed tx_out through a 3-sample majority receiver; invert one of the three samples in every symbol.
  - Send random words, including 0x00 and 0xFF → every word is recovered.
  - Also run with parameters REP=1, NBITS=4, in_data=0x9 → 6-cycle frame 0,1,0,0,1,1.
